// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch queue, the instruction memory and decode.
// The master modport is the fetch queue itself; the slave modport is its environment.
interface fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    logic                         redirect_valid;
    logic [XLEN-1:0]              redirect_pc;
    logic                         imem_req_valid;
    logic                         imem_req_ready;
    logic [XLEN-1:0]              imem_req_addr;
    logic                         imem_rsp_valid;
    logic [XLEN-1:0]              imem_rsp_data;
    logic                         id_valid;
    logic                         id_ready;
    logic [XLEN-1:0]              id_instr;
    logic [XLEN-1:0]              id_pc;
    logic [XLEN-1:0]              id_pc_plus_4;
    logic [$clog2(DEPTH+1)-1:0]   occupancy;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
        output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus_4, occupancy
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
        input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, id_pc_plus_4, occupancy
    );
endinterface

// File: rtl/fetch_queue.sv
// Decoupled instruction-fetch front end: sequential PC generation, credit-limited
// requests to an in-order variable-latency imem, and a {pc, instr} FIFO towards decode.
module fetch_queue #(
    parameter int              XLEN            = 32,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input logic           clk,
    input logic           reset,
    fetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [XLEN-1:0] fetch_pc;
    logic [IW-1:0]   inflight;
    logic [IW-1:0]   drop;
    logic [IW-1:0]   live;
    logic [CW-1:0]   count;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [PW-1:0]   pc_rd;
    logic [PW-1:0]   pc_wr;

    logic [XLEN-1:0] pc_fifo   [MAX_OUTSTANDING];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    logic redirect;
    logic req_valid;
    logic req_fire;
    logic rsp_fire;
    logic push;
    logic pop;
    logic id_valid;
    logic credit_ok;

    function automatic logic [PW-1:0] pc_next(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    assign redirect  = bus.redirect_valid;
    assign live      = inflight - drop;
    // Every live response must already own a FIFO slot, so responses never stall.
    assign credit_ok = ({1'b0, count} + (CW+1)'(live)) < (CW+1)'(DEPTH);
    assign req_valid = reset && !redirect && (inflight < IW'(MAX_OUTSTANDING)) && credit_ok;
    assign req_fire  = req_valid && bus.imem_req_ready;
    assign rsp_fire  = bus.imem_rsp_valid;
    assign push      = rsp_fire && (drop == '0) && !redirect;
    assign id_valid  = (count != '0);
    assign pop       = id_valid && bus.id_ready && !redirect;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            pc_rd    <= '0;
            pc_wr    <= '0;
        end else begin
            inflight <= inflight + IW'(req_fire) - IW'(rsp_fire);
            if (req_fire) pc_wr <= pc_next(pc_wr);
            if (rsp_fire) pc_rd <= pc_next(pc_rd);

            if (redirect) begin
                // Recomputing from inflight makes back-to-back redirects self-correcting.
                fetch_pc <= bus.redirect_pc;
                drop     <= inflight - IW'(rsp_fire);
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
                if (rsp_fire && drop != '0) drop <= drop - IW'(1);
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // NOTE: storage arrays carry no reset; pointers and count define validity and id_* are gated by id_valid.
    always_ff @(posedge clk) begin
        if (req_fire) pc_fifo[pc_wr] <= fetch_pc;
        if (push) begin
            pc_mem[wr_ptr]    <= pc_fifo[pc_rd];
            instr_mem[wr_ptr] <= bus.imem_rsp_data;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.id_valid       = id_valid;
    assign bus.id_pc          = id_valid ? pc_mem[rd_ptr] : '0;
    assign bus.id_instr       = id_valid ? instr_mem[rd_ptr] : '0;
    assign bus.id_pc_plus_4   = bus.id_pc + XLEN'(4);
    assign bus.occupancy      = count;

    a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && count == CW'(DEPTH)));

    a_rsp_has_req : assert property (@(posedge clk) disable iff (!reset)
        bus.imem_rsp_valid |-> (inflight != '0));
endmodule
